colormem_ctrl: RTL and testbench



---
 rtl/colormem_ctrl_pkg.sv | 19 +
 rtl/colormem_ctrl_if.sv | 45 ++++
 rtl/colormem_ctrl_fill.sv | 76 +++++++
 rtl/colormem_ctrl.sv | 102 ++++++++++
 tb/tb_colormem_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/colormem_ctrl_pkg.sv
// Shared colour-memory types for the xv video block: data word, write record, fill FSM states.
package xv;

    localparam int unsigned COLORMEM_AWIDTH = 8;

    typedef logic [15:0] word_t;

    typedef struct packed {
        logic                       en;
        logic [COLORMEM_AWIDTH:0]   addr;
        word_t                      data;
    } colormem_wr_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/colormem_ctrl_if.sv
// Request/response bundle of colormem_ctrl: copper, host, fill control and colormem write side.
interface colormem_ctrl_if #(
    parameter int unsigned AWIDTH = 8
);
    import xv::*;

    logic              cop_wr_i;
    logic [AWIDTH:0]   cop_addr_i;
    word_t             cop_data_i;
    logic              host_req_i;
    logic [AWIDTH:0]   host_addr_i;
    word_t             host_data_i;
    logic              host_ack_o;
    logic              fill_start_i;
    logic              fill_abort_i;
    logic [AWIDTH:0]   fill_first_i;
    logic [AWIDTH:0]   fill_last_i;
    word_t             fill_data_i;
    word_t             fill_inc_i;
    logic              fill_busy_o;
    logic              fill_done_o;
    logic              wr_en_a_o;
    logic              wr_en_b_o;
    logic [AWIDTH-1:0] wr_address_o;
    word_t             wr_data_o;

    modport master (
        output cop_wr_i, cop_addr_i, cop_data_i,
        output host_req_i, host_addr_i, host_data_i,
        input  host_ack_o,
        output fill_start_i, fill_abort_i, fill_first_i, fill_last_i, fill_data_i, fill_inc_i,
        input  fill_busy_o, fill_done_o,
        input  wr_en_a_o, wr_en_b_o, wr_address_o, wr_data_o
    );

    modport slave (
        input  cop_wr_i, cop_addr_i, cop_data_i,
        input  host_req_i, host_addr_i, host_data_i,
        output host_ack_o,
        input  fill_start_i, fill_abort_i, fill_first_i, fill_last_i, fill_data_i, fill_inc_i,
        output fill_busy_o, fill_done_o,
        output wr_en_a_o, wr_en_b_o, wr_address_o, wr_data_o
    );

endinterface

// File: rtl/colormem_ctrl_fill.sv
// Palette fill engine: walks first..last (wrapping) writing an arithmetic data ramp,
// one entry per cycle the arbiter leaves free.
module colormem_fill
    import xv::*;
#(
    parameter int unsigned AWIDTH = 8
) (
    input  logic            clk,
    input  logic            reset_n_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [AWIDTH:0] first_i,
    input  logic [AWIDTH:0] last_i,
    input  word_t           data_i,
    input  word_t           inc_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [AWIDTH:0] addr_o,
    output word_t           data_o,
    output logic            busy_o,
    output logic            done_o
);

    fill_state_t     state_q;
    logic [AWIDTH:0] cur_addr_q;
    logic [AWIDTH:0] last_q;
    word_t           cur_data_q;
    word_t           inc_q;
    logic            done_q;

    // An abort cycle must not issue a write, so it masks the request directly.
    assign valid_o = (state_q == FILL) && !abort_i;
    assign addr_o  = cur_addr_q;
    assign data_o  = cur_data_q;
    assign busy_o  = (state_q == FILL);
    assign done_o  = done_q;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            last_q     <= '0;
            cur_data_q <= '0;
            inc_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state_q    <= FILL;
                        cur_addr_q <= first_i;
                        last_q     <= last_i;
                        cur_data_q <= data_i;
                        inc_q      <= inc_i;
                    end
                end
                FILL: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else if (ready_i) begin
                        if (cur_addr_q == last_q) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cur_addr_q <= cur_addr_q + (AWIDTH+1)'(1);
                            cur_data_q <= cur_data_q + inc_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/colormem_ctrl.sv
// Colour-memory write-port arbiter (copper > host > fill) with playfield A/B enable decode.
// Fill engine present only when EN_COLORMEM_FILL_EN is defined.
module colormem_ctrl
    import xv::*;
#(
    parameter int unsigned AWIDTH = 8
) (
    input logic            clk,
    input logic            reset_n_i,
    colormem_ctrl_if.slave bus
);

    logic            fill_valid;
    logic [AWIDTH:0] fill_addr;
    word_t           fill_data;
    logic            fill_ready;

    logic            win_en_d;
    logic [AWIDTH:0] win_addr_d;
    word_t           win_data_d;

    logic              wr_en_a_q;
    logic              wr_en_b_q;
    logic [AWIDTH-1:0] wr_address_q;
    word_t             wr_data_q;

    assign bus.host_ack_o = bus.host_req_i & ~bus.cop_wr_i;
    assign fill_ready     = ~bus.cop_wr_i & ~bus.host_req_i;

`ifdef EN_COLORMEM_FILL_EN
    colormem_fill #(
        .AWIDTH(AWIDTH)
    ) u_fill (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .start_i   (bus.fill_start_i),
        .abort_i   (bus.fill_abort_i),
        .first_i   (bus.fill_first_i),
        .last_i    (bus.fill_last_i),
        .data_i    (bus.fill_data_i),
        .inc_i     (bus.fill_inc_i),
        .ready_i   (fill_ready),
        .valid_o   (fill_valid),
        .addr_o    (fill_addr),
        .data_o    (fill_data),
        .busy_o    (bus.fill_busy_o),
        .done_o    (bus.fill_done_o)
    );
`else
    logic unused_fill;

    assign fill_valid      = 1'b0;
    assign fill_addr       = '0;
    assign fill_data       = '0;
    assign bus.fill_busy_o = 1'b0;
    assign bus.fill_done_o = 1'b0;
    assign unused_fill     = ^{bus.fill_start_i, bus.fill_abort_i, bus.fill_first_i,
                               bus.fill_last_i, bus.fill_data_i, bus.fill_inc_i, fill_ready};
`endif

    always_comb begin
        win_en_d   = 1'b0;
        win_addr_d = '0;
        win_data_d = '0;
        if (bus.cop_wr_i) begin
            win_en_d   = 1'b1;
            win_addr_d = bus.cop_addr_i;
            win_data_d = bus.cop_data_i;
        end else if (bus.host_req_i) begin
            win_en_d   = 1'b1;
            win_addr_d = bus.host_addr_i;
            win_data_d = bus.host_data_i;
        end else if (fill_valid) begin
            win_en_d   = 1'b1;
            win_addr_d = fill_addr;
            win_data_d = fill_data;
        end
    end

    // Address/data hold their last written value on idle cycles; only the enables pulse.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_en_a_q    <= 1'b0;
            wr_en_b_q    <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
        end else begin
            wr_en_a_q <= win_en_d & ~win_addr_d[AWIDTH];
            wr_en_b_q <= win_en_d &  win_addr_d[AWIDTH];
            if (win_en_d) begin
                wr_address_q <= win_addr_d[AWIDTH-1:0];
                wr_data_q    <= win_data_d;
            end
        end
    end

    assign bus.wr_en_a_o    = wr_en_a_q;
    assign bus.wr_en_b_o    = wr_en_b_q;
    assign bus.wr_address_o = wr_address_q;
    assign bus.wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_colormem_ctrl.sv
// Self-checking bench for colormem_ctrl; reference model is a queue of pending fill entries.
// Fill expectations follow EN_COLORMEM_FILL_EN the same way the RTL does.
module tb_colormem_ctrl;
    import xv::*;

`ifdef EN_COLORMEM_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    typedef struct {
        logic [8:0]  a;
        logic [15:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n_i;
    int   checks = 0;
    int   errors = 0;
    ent_t fq[$];

    colormem_ctrl_if #(.AWIDTH(8)) bus ();

    colormem_ctrl #(.AWIDTH(8)) dut (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus.cop_wr_i     = 1'b0;
        bus.host_req_i   = 1'b0;
        bus.fill_start_i = 1'b0;
        bus.fill_abort_i = 1'b0;
    endtask

    task automatic set_fill(input logic [8:0] first, input logic [8:0] last,
                            input logic [15:0] data, input logic [15:0] inc);
        bus.fill_first_i = first;
        bus.fill_last_i  = last;
        bus.fill_data_i  = data;
        bus.fill_inc_i   = inc;
    endtask

    // Enumerate every entry a fill will write, straight from first/last/data/inc.
    task automatic enqueue_fill(input logic [8:0] first, input logic [8:0] last,
                                input logic [15:0] data, input logic [15:0] inc);
        int unsigned n;
        ent_t e;
        n = ((int'(last) - int'(first)) & 32'h1FF) + 1;
        for (int unsigned i = 0; i < n; i++) begin
            e.a = 9'((int'(first) + i) % 512);
            e.d = 16'(int'(data) + i * int'(inc));
            fq.push_back(e);
        end
    endtask

    // One clock: check ack on current inputs, predict the write, then check registered outputs.
    task automatic step(input string tag);
        logic        exp_w;
        logic        exp_done;
        logic        busy_before;
        logic [8:0]  wa;
        logic [15:0] wd;
        ent_t        e;
        exp_w    = 1'b0;
        exp_done = 1'b0;
        wa       = '0;
        wd       = '0;
        #1;
        check({tag, ".ack"}, 32'(bus.host_ack_o), 32'(bus.host_req_i && !bus.cop_wr_i));
        busy_before = (fq.size() > 0);
        if (bus.cop_wr_i) begin
            exp_w = 1'b1; wa = bus.cop_addr_i; wd = bus.cop_data_i;
        end else if (bus.host_req_i) begin
            exp_w = 1'b1; wa = bus.host_addr_i; wd = bus.host_data_i;
        end else if (busy_before && !bus.fill_abort_i) begin
            e = fq.pop_front();
            exp_w = 1'b1; wa = e.a; wd = e.d;
            exp_done = (fq.size() == 0);
        end
        if (busy_before && bus.fill_abort_i)
            fq.delete();
        else if (FILL_EN && !busy_before && bus.fill_start_i && !bus.fill_abort_i)
            enqueue_fill(bus.fill_first_i, bus.fill_last_i, bus.fill_data_i, bus.fill_inc_i);
        @(posedge clk);
        #1;
        check({tag, ".en_a"}, 32'(bus.wr_en_a_o), 32'(exp_w && !wa[8]));
        check({tag, ".en_b"}, 32'(bus.wr_en_b_o), 32'(exp_w && wa[8]));
        if (exp_w) begin
            check({tag, ".addr"}, 32'(bus.wr_address_o), 32'(wa[7:0]));
            check({tag, ".data"}, 32'(bus.wr_data_o), 32'(wd));
        end
        check({tag, ".busy"}, 32'(bus.fill_busy_o), 32'(fq.size() > 0));
        check({tag, ".done"}, 32'(bus.fill_done_o), 32'(exp_done));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".en_a"}, 32'(bus.wr_en_a_o), 32'h0);
        check({tag, ".en_b"}, 32'(bus.wr_en_b_o), 32'h0);
        check({tag, ".addr"}, 32'(bus.wr_address_o), 32'h0);
        check({tag, ".data"}, 32'(bus.wr_data_o), 32'h0);
        check({tag, ".busy"}, 32'(bus.fill_busy_o), 32'h0);
        check({tag, ".done"}, 32'(bus.fill_done_o), 32'h0);
    endtask

    initial begin
        reset_n_i = 1'b0;
        quiet();
        bus.cop_addr_i  = '0;
        bus.cop_data_i  = '0;
        bus.host_addr_i = '0;
        bus.host_data_i = '0;
        set_fill('0, '0, '0, '0);
        bus.host_req_i = 1'b1;
        #3;
        check_all_zero("reset");
        check("reset.ack", 32'(bus.host_ack_o), 32'h1);
        bus.host_req_i = 1'b0;
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;

        // Host write to playfield A
        bus.host_req_i = 1'b1; bus.host_addr_i = 9'h005; bus.host_data_i = 16'h0F0F;
        step("host");
        quiet();
        step("host_idle");

        // Copper and host collide; host held until acked
        bus.cop_wr_i = 1'b1; bus.cop_addr_i = 9'h1FF; bus.cop_data_i = 16'h1234;
        bus.host_req_i = 1'b1; bus.host_addr_i = 9'h010; bus.host_data_i = 16'hBEEF;
        step("coll_cop");
        bus.cop_wr_i = 1'b0;
        step("coll_host");
        quiet();
        step("coll_idle");

        // Fill crossing from A into B
        set_fill(9'h0FE, 9'h101, 16'h0000, 16'h0111);
        bus.fill_start_i = 1'b1;
        step("fill_ab_start");
        quiet();
        for (int i = 0; i < 6; i++) step("fill_ab");

        // Fill stalled by interleaved host writes; restart attempt mid-fill ignored
        set_fill(9'h020, 9'h027, 16'h1000, 16'h0003);
        bus.fill_start_i = 1'b1;
        step("fill_host_start");
        quiet();
        for (int i = 0; i < 16; i++) begin
            bus.host_req_i   = (i % 3 != 2);
            bus.host_addr_i  = 9'(9'h130 + i);
            bus.host_data_i  = 16'(16'hA000 + i);
            bus.fill_start_i = (i == 4);
            step("fill_host");
        end
        quiet();
        for (int i = 0; i < 6; i++) step("fill_host_drain");

        // Wraparound fill through the top of the address space
        set_fill(9'h1FF, 9'h000, 16'h7FFF, 16'h8001);
        bus.fill_start_i = 1'b1;
        step("fill_wrap_start");
        quiet();
        for (int i = 0; i < 4; i++) step("fill_wrap");

        // Single-entry fill, and abort+start together in IDLE
        set_fill(9'h077, 9'h077, 16'h5555, 16'h1111);
        bus.fill_start_i = 1'b1;
        step("fill_one_start");
        quiet();
        for (int i = 0; i < 3; i++) step("fill_one");
        bus.fill_start_i = 1'b1; bus.fill_abort_i = 1'b1;
        step("start_abort_idle");
        quiet();
        for (int i = 0; i < 3; i++) step("start_abort_after");

        // Abort after two of eight writes
        set_fill(9'h040, 9'h047, 16'h0100, 16'h0010);
        bus.fill_start_i = 1'b1;
        step("abort_start");
        quiet();
        step("abort_w1");
        step("abort_w2");
        bus.fill_abort_i = 1'b1;
        step("abort");
        quiet();
        for (int i = 0; i < 8; i++) step("abort_after");

        // Reset asserted mid-fill clears everything asynchronously
        set_fill(9'h180, 9'h18F, 16'h0042, 16'h0001);
        bus.fill_start_i = 1'b1;
        step("rst_fill_start");
        quiet();
        step("rst_fill_w1");
        step("rst_fill_w2");
        reset_n_i = 1'b0;
        #1;
        check_all_zero("rst_mid");
        fq.delete();
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) step("rst_after");

        // Randomized mixed traffic
        for (int i = 0; i < 600; i++) begin
            bus.cop_wr_i     = ($urandom_range(0, 3) == 0);
            bus.cop_addr_i   = 9'($urandom);
            bus.cop_data_i   = 16'($urandom);
            bus.host_req_i   = ($urandom_range(0, 2) == 0);
            bus.host_addr_i  = 9'($urandom);
            bus.host_data_i  = 16'($urandom);
            bus.fill_start_i = ($urandom_range(0, 19) == 0);
            bus.fill_abort_i = ($urandom_range(0, 59) == 0);
            bus.fill_first_i = 9'($urandom);
            bus.fill_last_i  = 9'(bus.fill_first_i + 9'($urandom_range(0, 24)));
            bus.fill_data_i  = 16'($urandom);
            bus.fill_inc_i   = 16'($urandom);
            step("rand");
        end
        quiet();
        for (int i = 0; i < 40; i++) step("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
